// File: rtl/bdf_sched_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : bdf_sched_sequencer
// Purpose  : Cyclic schedule sequencer for the BDF buffer array. A static
//            schedule of ITER_PERIOD rows is loaded serially (one row per
//            load_ctrl cycle), then replayed row by row on start, wrapping
//            every iteration, producing per-buffer wr/rd toggle strobes.
//            A stop request halts replay at the next iteration boundary.
// Ports    : clk            - clock, rising edge
//            rst            - asynchronous active-low reset
//            load_ctrl      - write ctrl_in into next table row
//            start_ctrl     - begin cyclic replay (READY only)
//            stop_ctrl      - halt at end of current iteration
//            ctrl_in        - schedule row, bit 2i = wr, bit 2i+1 = rd of buffer i
//            buff_wr_toggle - per-buffer write toggle strobe
//            buff_rd_toggle - per-buffer read toggle strobe
//            tbl_valid      - complete table loaded
//            running        - replay active (RUN or STOP_PEND)
//            iter_done      - pulse concurrent with last row output
//            iter_count     - completed iterations since start, saturating
//            cfg_err        - sticky illegal-command flag
// Revision : 1.0 - initial release
// ============================================================================
module bdf_sched_sequencer #(
    parameter int NUM_BUFFS   = 12,
    parameter int CTRL_WIDTH  = NUM_BUFFS * 2,
    parameter int ITER_PERIOD = 48,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_ctrl,
    input  logic                  start_ctrl,
    input  logic                  stop_ctrl,
    input  logic [CTRL_WIDTH-1:0] ctrl_in,
    output logic [NUM_BUFFS-1:0]  buff_wr_toggle,
    output logic [NUM_BUFFS-1:0]  buff_rd_toggle,
    output logic                  tbl_valid,
    output logic                  running,
    output logic                  iter_done,
    output logic [CNT_WIDTH-1:0]  iter_count,
    output logic                  cfg_err
);

    localparam int                 C_PTR_W    = (ITER_PERIOD > 1) ? $clog2(ITER_PERIOD) : 1;
    localparam logic [C_PTR_W-1:0] C_LAST_ROW = C_PTR_W'(ITER_PERIOD - 1);
    localparam logic [C_PTR_W-1:0] C_ROW_ONE  = C_PTR_W'(1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD      = 3'd1,
        S_READY     = 3'd2,
        S_RUN       = 3'd3,
        S_STOP_PEND = 3'd4
    } state_t;

    state_t                 state_q,      state_d;
    logic [C_PTR_W-1:0]     ptr_q,        ptr_d;
    logic [C_PTR_W-1:0]     step_q,       step_d;
    logic [CTRL_WIDTH-1:0]  row_out_q,    row_out_d;
    logic                   tbl_valid_q,  tbl_valid_d;
    logic                   running_q,    running_d;
    logic                   iter_done_q,  iter_done_d;
    logic [CNT_WIDTH-1:0]   iter_count_q, iter_count_d;
    logic                   cfg_err_q,    cfg_err_d;

    // Schedule storage: deliberately not reset; tbl_valid gates its use.
    logic [CTRL_WIDTH-1:0]  tbl_mem [ITER_PERIOD];
    logic                   tbl_we;
    logic [C_PTR_W-1:0]     tbl_waddr;

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        step_d       = step_q;
        row_out_d    = '0;
        tbl_valid_d  = tbl_valid_q;
        iter_done_d  = 1'b0;
        iter_count_d = iter_count_q;
        cfg_err_d    = cfg_err_q;
        tbl_we       = 1'b0;
        tbl_waddr    = ptr_q;

        case (state_q)
            S_IDLE, S_READY: begin
                if (load_ctrl) begin
                    // A new load restarts the table; a concurrent start is
                    // still illegal, so the error flag follows start_ctrl.
                    tbl_we      = 1'b1;
                    tbl_waddr   = '0;
                    ptr_d       = C_ROW_ONE;
                    tbl_valid_d = 1'b0;
                    cfg_err_d   = start_ctrl;
                    state_d     = S_LOAD;
                end else if (start_ctrl) begin
                    if (state_q == S_IDLE) begin
                        cfg_err_d = 1'b1;
                    end else if (!stop_ctrl) begin
                        row_out_d    = tbl_mem[0];
                        step_d       = C_ROW_ONE;
                        iter_count_d = '0;
                        state_d      = S_RUN;
                    end
                end
            end

            S_LOAD: begin
                if (start_ctrl) begin
                    cfg_err_d = 1'b1;
                end
                if (load_ctrl) begin
                    tbl_we = 1'b1;
                    if (ptr_q == C_LAST_ROW) begin
                        ptr_d       = '0;
                        tbl_valid_d = 1'b1;
                        state_d     = S_READY;
                    end else begin
                        ptr_d = ptr_q + 1'b1;
                    end
                end
            end

            S_RUN, S_STOP_PEND: begin
                if (load_ctrl) begin
                    cfg_err_d = 1'b1;
                end
                // step_q == 0 means the next edge would present row 0 again:
                // that is the iteration boundary where a pending stop lands.
                if ((state_q == S_STOP_PEND) && (step_q == '0)) begin
                    state_d = S_READY;
                end else begin
                    row_out_d = tbl_mem[step_q];
                    step_d    = (step_q == C_LAST_ROW) ? '0 : step_q + 1'b1;
                    if (step_q == C_LAST_ROW) begin
                        iter_done_d = 1'b1;
                        if (iter_count_q != {CNT_WIDTH{1'b1}}) begin
                            iter_count_d = iter_count_q + 1'b1;
                        end
                    end
                    if ((state_q == S_RUN) && stop_ctrl) begin
                        state_d = S_STOP_PEND;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        running_d = (state_d == S_RUN) || (state_d == S_STOP_PEND);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            ptr_q        <= '0;
            step_q       <= '0;
            row_out_q    <= '0;
            tbl_valid_q  <= 1'b0;
            running_q    <= 1'b0;
            iter_done_q  <= 1'b0;
            iter_count_q <= '0;
            cfg_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            step_q       <= step_d;
            row_out_q    <= row_out_d;
            tbl_valid_q  <= tbl_valid_d;
            running_q    <= running_d;
            iter_done_q  <= iter_done_d;
            iter_count_q <= iter_count_d;
            cfg_err_q    <= cfg_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (tbl_we) begin
            tbl_mem[tbl_waddr] <= ctrl_in;
        end
    end

    generate
        for (genvar i = 0; i < NUM_BUFFS; i++) begin : g_unpack
            assign buff_wr_toggle[i] = row_out_q[2*i];
            assign buff_rd_toggle[i] = row_out_q[2*i+1];
        end
    endgenerate

    assign tbl_valid  = tbl_valid_q;
    assign running    = running_q;
    assign iter_done  = iter_done_q;
    assign iter_count = iter_count_q;
    assign cfg_err    = cfg_err_q;

endmodule
`default_nettype wire

// File: tb/tb_bdf_sched_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_bdf_sched_sequencer
// Purpose  : Self-checking bench for bdf_sched_sequencer. A schedule-level
//            model predicts every output each cycle; directed literal checks
//            pin key cycles. A second instance with a 4-bit iteration
//            counter exposes counter saturation in a short run.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bdf_sched_sequencer;

    localparam int NB   = 12;
    localparam int CW   = 24;
    localparam int IP   = 48;
    localparam int CNTW = 16;

    logic          clk        = 1'b0;
    logic          rst        = 1'b0;
    logic          load_ctrl  = 1'b0;
    logic          start_ctrl = 1'b0;
    logic          stop_ctrl  = 1'b0;
    logic [CW-1:0] ctrl_in    = '0;

    logic [NB-1:0]   wr, rd, wr_s, rd_s;
    logic            tbl_valid, running, iter_done, cfg_err;
    logic            tv_s, run_s, done_s, err_s;
    logic [CNTW-1:0] iter_count;
    logic [3:0]      cnt_s;

    always #5 clk = ~clk;

    bdf_sched_sequencer #(.NUM_BUFFS(NB), .CTRL_WIDTH(CW), .ITER_PERIOD(IP), .CNT_WIDTH(CNTW)) dut (
        .clk(clk), .rst(rst), .load_ctrl(load_ctrl), .start_ctrl(start_ctrl),
        .stop_ctrl(stop_ctrl), .ctrl_in(ctrl_in), .buff_wr_toggle(wr), .buff_rd_toggle(rd),
        .tbl_valid(tbl_valid), .running(running), .iter_done(iter_done),
        .iter_count(iter_count), .cfg_err(cfg_err)
    );

    bdf_sched_sequencer #(.NUM_BUFFS(NB), .CTRL_WIDTH(CW), .ITER_PERIOD(IP), .CNT_WIDTH(4)) dut_s (
        .clk(clk), .rst(rst), .load_ctrl(load_ctrl), .start_ctrl(start_ctrl),
        .stop_ctrl(stop_ctrl), .ctrl_in(ctrl_in), .buff_wr_toggle(wr_s), .buff_rd_toggle(rd_s),
        .tbl_valid(tv_s), .running(run_s), .iter_done(done_s),
        .iter_count(cnt_s), .cfg_err(err_s)
    );

    int checks = 0;
    int errors = 0;

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- schedule-level model ----------------
    logic [CW-1:0] m_tbl [IP];
    int            m_nw       = 0;
    bit            m_loading  = 0;
    bit            m_tbl_ok   = 0;
    bit            m_play     = 0;
    bit            m_stopping = 0;
    bit            m_err      = 0;
    bit            m_done     = 0;
    int            m_pos      = 0;
    int            m_cnt      = 0;
    logic [CW-1:0] m_row      = '0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_nw = 0; m_loading = 0; m_tbl_ok = 0; m_play = 0; m_stopping = 0;
            m_err = 0; m_done = 0; m_pos = 0; m_cnt = 0; m_row = '0;
        end else begin
            m_done = 0;
            if (m_play) begin
                if (load_ctrl) m_err = 1;
                if (m_stopping && m_pos == IP-1) begin
                    m_play = 0; m_stopping = 0; m_row = '0;
                end else begin
                    if (stop_ctrl) m_stopping = 1;
                    m_pos  = (m_pos + 1) % IP;
                    m_row  = m_tbl[m_pos];
                    m_done = (m_pos == IP-1);
                    if (m_done && m_cnt < 65535) m_cnt++;
                end
            end else if (m_loading) begin
                if (start_ctrl) m_err = 1;
                if (load_ctrl) begin
                    m_tbl[m_nw] = ctrl_in;
                    m_nw++;
                    if (m_nw == IP) begin
                        m_loading = 0; m_tbl_ok = 1;
                    end
                end
            end else begin
                m_row = '0;
                if (load_ctrl) begin
                    m_tbl[0] = ctrl_in; m_nw = 1; m_loading = 1; m_tbl_ok = 0; m_err = start_ctrl;
                end else if (start_ctrl && !m_tbl_ok) begin
                    m_err = 1;
                end else if (start_ctrl && !stop_ctrl) begin
                    m_play = 1; m_pos = 0; m_row = m_tbl[0]; m_cnt = 0;
                end
            end
        end
    end

    function automatic logic [NB-1:0] pick(input logic [CW-1:0] r, input int odd);
        logic [NB-1:0] v;
        for (int i = 0; i < NB; i++) v[i] = r[2*i+odd];
        return v;
    endfunction

    always @(negedge clk) begin
        cmp("wr_toggle",   wr,         pick(m_row, 0));
        cmp("rd_toggle",   rd,         pick(m_row, 1));
        cmp("tbl_valid",   tbl_valid,  m_tbl_ok);
        cmp("running",     running,    m_play);
        cmp("iter_done",   iter_done,  m_done);
        cmp("iter_count",  iter_count, m_cnt);
        cmp("cfg_err",     cfg_err,    m_err);
        cmp("count_sat4",  cnt_s,      (m_cnt > 15) ? 15 : m_cnt);
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [CW-1:0] pat(input int w);
        logic [31:0] t;
        t = (w * 32'h9E37) ^ 32'h005A5A5A;
        return t[CW-1:0];
    endfunction

    initial begin
        repeat (3) tick();
        cmp("rst_running", running, 0);
        cmp("rst_count", iter_count, 0);
        rst = 1'b1;
        tick();

        // start without a table is illegal
        start_ctrl = 1'b1; tick(); start_ctrl = 1'b0;
        cmp("err_no_table", cfg_err, 1);
        cmp("tog_no_table", {wr, rd}, 0);

        // contiguous load, row r = r
        for (int r = 0; r < IP; r++) begin
            load_ctrl = 1'b1; ctrl_in = CW'(r); tick();
            if (r == 0) cmp("err_cleared_by_load", cfg_err, 0);
        end
        load_ctrl = 1'b0;
        cmp("valid_after_load", tbl_valid, 1);

        // start+stop together in READY: stop wins, no error
        start_ctrl = 1'b1; stop_ctrl = 1'b1; tick();
        start_ctrl = 1'b0; stop_ctrl = 1'b0;
        cmp("startstop_running", running, 0);
        cmp("startstop_err", cfg_err, 0);
        tick();

        // replay: k counts negedges after start
        start_ctrl = 1'b1; tick(); start_ctrl = 1'b0;       // k=0
        cmp("k0_wr", wr, 12'h000); cmp("k0_rd", rd, 12'h000); cmp("k0_running", running, 1);
        tick();                                             // k=1
        cmp("k1_wr", wr, 12'h001); cmp("k1_rd", rd, 12'h000);
        repeat (2) tick();                                  // k=3
        cmp("k3_wr", wr, 12'h001); cmp("k3_rd", rd, 12'h001);
        repeat (26) tick();                                 // k=29
        cmp("err_before_run_load", cfg_err, 0);
        load_ctrl = 1'b1; ctrl_in = '1; tick(); load_ctrl = 1'b0;   // k=30
        cmp("err_run_load", cfg_err, 1);
        repeat (17) tick();                                 // k=47
        cmp("k47_wr", wr, 12'h003); cmp("k47_rd", rd, 12'h007);
        cmp("k47_done", iter_done, 1); cmp("k47_count", iter_count, 1);
        tick();                                             // k=48
        cmp("k48_wr", wr, 12'h000); cmp("k48_done", iter_done, 0);
        repeat (10) tick();                                 // k=58, row 10
        stop_ctrl = 1'b1; tick(); stop_ctrl = 1'b0;         // k=59
        repeat (36) tick();                                 // k=95, row 47
        cmp("stop_last_running", running, 1);
        cmp("stop_last_count", iter_count, 2);
        tick();                                             // k=96
        cmp("stopped_running", running, 0);
        cmp("stopped_tog", {wr, rd}, 0);

        // restart from row 0, then async reset at row 20
        start_ctrl = 1'b1; tick(); start_ctrl = 1'b0;
        cmp("restart_row0", {wr, rd}, 0);
        repeat (20) tick();
        cmp("row20_wr", wr, 12'h006); cmp("row20_rd", rd, 12'h000);
        #2 rst = 1'b0;
        #1;
        cmp("async_rst_tog", {wr, rd}, 0);
        cmp("async_rst_running", running, 0);
        cmp("async_rst_valid", tbl_valid, 0);
        tick(); rst = 1'b1; tick();
        start_ctrl = 1'b1; tick(); start_ctrl = 1'b0;
        cmp("err_after_rst", cfg_err, 1);
        cmp("valid_after_rst", tbl_valid, 0);

        // gapped load (1,0,0) with an illegal start while loading
        for (int w = 0; w < IP; w++) begin
            load_ctrl = 1'b1; ctrl_in = pat(w); tick(); load_ctrl = 1'b0;
            cmp("valid_gap_load", tbl_valid, (w == IP-1));
            if (w == 0) cmp("err_cleared_gap", cfg_err, 0);
            if (w == 5) start_ctrl = 1'b1;
            tick(); start_ctrl = 1'b0;
            if (w == 5) cmp("err_start_in_load", cfg_err, 1);
            tick();
        end

        // long replay of gapped table: counter growth and 4-bit saturation
        start_ctrl = 1'b1; tick(); start_ctrl = 1'b0;
        cmp("gap_row0_wr", wr, 12'hCCC); cmp("gap_row0_rd", rd, 12'h333);
        repeat (20*IP - 1) tick();
        cmp("count_20", iter_count, 20);
        cmp("count_sat_15", cnt_s, 4'hF);
        stop_ctrl = 1'b1; tick(); stop_ctrl = 1'b0;
        repeat (IP + 4) tick();
        cmp("final_running", running, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
